// File: rtl/id_issue_param.sv
// id_issue_param: operand-issue stage between predecode and execute.
// Holds one decoded instruction, resolves two source operands from NBYP
// bypass sources (index 0 = youngest) or the register file, and issues to
// execute on a valid/allow_in handshake. Resolved operands are latched while
// execute back-pressures, so a retiring bypass value is not lost.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   in_*                     upstream instruction + in_allow_in handshake
//   rf_raddr*/rf_rdata*      combinational register-file read
//   byp_addr/wen/dvalid/data packed bypass buses, NBYP sources
//   flush                    kill held instruction (and same-cycle offer)
//   out_*                    issue to execute + out_allow_in handshake
//   stall_cnt                saturating count of operand-stall cycles

// Per-operand resolver: disabled / x0 / captured / first bypass hit / RF.
module id_issue_opnd #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NBYP = 3
) (
  input  logic                      en,
  input  logic [AW-1:0]             rs,
  input  logic                      cap,
  input  logic [XLEN-1:0]           hold,
  input  logic [NBYP-1:0][AW-1:0]   byp_addr,
  input  logic [NBYP-1:0]           byp_wen,
  input  logic [NBYP-1:0]           byp_dvalid,
  input  logic [NBYP-1:0][XLEN-1:0] byp_data,
  input  logic [XLEN-1:0]           rf_rdata,
  output logic                      ready,
  output logic [XLEN-1:0]           value
);
  logic hit;

  always_comb begin
    ready = 1'b1;
    value = '0;
    hit   = 1'b0;
    if (en && rs != '0) begin
      if (cap) begin
        value = hold;
      end else begin
        // Youngest matching source decides, even if an older one is final.
        for (int k = 0; k < NBYP; k++) begin
          if (!hit && byp_wen[k] && byp_addr[k] == rs) begin
            hit   = 1'b1;
            ready = byp_dvalid[k];
            value = byp_data[k];
          end
        end
        if (!hit) value = rf_rdata;
      end
    end
  end
endmodule

module id_issue_param #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NBYP = 3,
  parameter int PW   = 96,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_allow_in,
  input  logic [AW-1:0]        in_rs1,
  input  logic [AW-1:0]        in_rs2,
  input  logic                 in_rs1_en,
  input  logic                 in_rs2_en,
  input  logic [AW-1:0]        in_rd,
  input  logic                 in_rd_en,
  input  logic [PW-1:0]        in_payload,
  output logic [AW-1:0]        rf_raddr1,
  output logic [AW-1:0]        rf_raddr2,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  input  logic [NBYP*AW-1:0]   byp_addr,
  input  logic [NBYP-1:0]      byp_wen,
  input  logic [NBYP-1:0]      byp_dvalid,
  input  logic [NBYP*XLEN-1:0] byp_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_allow_in,
  output logic [XLEN-1:0]      out_src1,
  output logic [XLEN-1:0]      out_src2,
  output logic [AW-1:0]        out_rd,
  output logic                 out_rd_en,
  output logic [PW-1:0]        out_payload,
  output logic [31:0]          stall_cnt
);
  logic                      valid;
  logic [1:0][AW-1:0]        rs_q;
  logic [1:0]                en_q;
  logic [AW-1:0]             rd_q;
  logic                      rd_en_q;
  logic [PW-1:0]             payload_q;
  logic [1:0]                cap;
  logic [1:0][XLEN-1:0]      hold;
  logic [31:0]               stall_q;

  logic [NBYP-1:0][AW-1:0]   byp_addr_a;
  logic [NBYP-1:0][XLEN-1:0] byp_data_a;
  logic [1:0][XLEN-1:0]      rf_rdata_a;
  logic [1:0]                ready;
  logic [1:0][XLEN-1:0]      value;
  logic                      ready_go, fire, accept;

  assign byp_addr_a = byp_addr;
  assign byp_data_a = byp_data;
  assign rf_rdata_a = {rf_rdata2, rf_rdata1};

  for (genvar i = 0; i < 2; i++) begin : g_opnd
    id_issue_opnd #(.XLEN(XLEN), .AW(AW), .NBYP(NBYP)) u_opnd (
      .en        (en_q[i]),
      .rs        (rs_q[i]),
      .cap       (cap[i]),
      .hold      (hold[i]),
      .byp_addr  (byp_addr_a),
      .byp_wen   (byp_wen),
      .byp_dvalid(byp_dvalid),
      .byp_data  (byp_data_a),
      .rf_rdata  (rf_rdata_a[i]),
      .ready     (ready[i]),
      .value     (value[i])
    );
  end

  assign ready_go    = &ready;
  assign out_valid   = valid & ready_go;
  assign fire        = out_valid & out_allow_in;
  assign in_allow_in = ~valid | (ready_go & out_allow_in);
  assign accept      = in_valid & in_allow_in;

  assign rf_raddr1   = rs_q[0];
  assign rf_raddr2   = rs_q[1];
  assign out_src1    = value[0];
  assign out_src2    = value[1];
  assign out_rd      = rd_q;
  assign out_rd_en   = rd_en_q;
  assign out_payload = payload_q;
  assign stall_cnt   = stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid     <= 1'b0;
      rs_q      <= '0;
      en_q      <= '0;
      rd_q      <= '0;
      rd_en_q   <= 1'b0;
      payload_q <= '0;
      cap       <= '0;
      hold      <= '0;
      stall_q   <= '0;
    end else begin
      // Only operand stalls count; back-pressure has ready_go = 1.
      if (valid && !ready_go && !flush && stall_q != 32'hFFFF_FFFF)
        stall_q <= stall_q + 32'd1;

      if (flush) begin
        valid <= 1'b0;
        cap   <= '0;
      end else if (accept) begin
        valid     <= 1'b1;
        cap       <= '0;
        rs_q      <= {in_rs2, in_rs1};
        en_q      <= {in_rs2_en, in_rs1_en};
        rd_q      <= in_rd;
        rd_en_q   <= in_rd_en;
        payload_q <= in_payload;
      end else if (fire) begin
        valid <= 1'b0;
        cap   <= '0;
      end else begin
        // Pin each operand the first cycle it resolves so a bypass that
        // moves on during back-pressure cannot change it.
        for (int i = 0; i < 2; i++) begin
          if (valid && ready[i] && !cap[i]) begin
            cap[i]  <= 1'b1;
            hold[i] <= value[i];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_id_issue_param.sv
module tb_id_issue_param;
  localparam int XLEN = 32, NREG = 32, NBYP = 3, PW = 96, AW = 5;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      in_valid, in_allow_in;
  logic [AW-1:0]             in_rs1, in_rs2, in_rd;
  logic                      in_rs1_en, in_rs2_en, in_rd_en;
  logic [PW-1:0]             in_payload;
  logic [AW-1:0]             rf_raddr1, rf_raddr2;
  logic [XLEN-1:0]           rf_rdata1, rf_rdata2;
  logic [NBYP-1:0][AW-1:0]   byp_addr;
  logic [NBYP-1:0]           byp_wen, byp_dvalid;
  logic [NBYP-1:0][XLEN-1:0] byp_data;
  logic                      flush, out_valid, out_allow_in, out_rd_en;
  logic [XLEN-1:0]           out_src1, out_src2;
  logic [AW-1:0]             out_rd;
  logic [PW-1:0]             out_payload;
  logic [31:0]               stall_cnt;

  always #5 clk = ~clk;

  // Register file model: x[n] = 0x1000 + n.
  assign rf_rdata1 = 32'h1000 + 32'(rf_raddr1);
  assign rf_rdata2 = 32'h1000 + 32'(rf_raddr2);

  id_issue_param #(.XLEN(XLEN), .NREG(NREG), .NBYP(NBYP), .PW(PW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_allow_in(in_allow_in),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en),
    .in_rd(in_rd), .in_rd_en(in_rd_en), .in_payload(in_payload),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .byp_addr(byp_addr), .byp_wen(byp_wen), .byp_dvalid(byp_dvalid), .byp_data(byp_data),
    .flush(flush), .out_valid(out_valid), .out_allow_in(out_allow_in),
    .out_src1(out_src1), .out_src2(out_src2), .out_rd(out_rd), .out_rd_en(out_rd_en),
    .out_payload(out_payload), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [XLEN-1:0] s1, s2;
    logic [AW-1:0]   rd;
    logic            rde;
    logic [PW-1:0]   pl;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed handshake pops one expected issue.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_allow_in) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", {96'd0, out_src1}, 128'hDEAD_0000);
        end else begin
          e = exp_q.pop_front();
          chk("issue_src1", 128'(out_src1), 128'(e.s1));
          chk("issue_src2", 128'(out_src2), 128'(e.s2));
          chk("issue_rd", 128'(out_rd), 128'(e.rd));
          chk("issue_rd_en", 128'(out_rd_en), 128'(e.rde));
          chk("issue_payload", 128'(out_payload), 128'(e.pl));
        end
      end
    end
  endtask

  task automatic offer(input logic [AW-1:0] r1, input logic e1, input logic [AW-1:0] r2,
                       input logic e2, input logic [AW-1:0] rd, input logic rde,
                       input logic [PW-1:0] pl, input logic [XLEN-1:0] s1,
                       input logic [XLEN-1:0] s2, input bit push);
    exp_t e;
    if (push) begin
      e.s1 = s1; e.s2 = s2; e.rd = rd; e.rde = rde; e.pl = pl;
      exp_q.push_back(e);
    end
    in_rs1 = r1; in_rs1_en = e1; in_rs2 = r2; in_rs2_en = e2;
    in_rd = rd; in_rd_en = rde; in_payload = pl; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic clr_byp();
    byp_addr = '0; byp_wen = '0; byp_dvalid = '0; byp_data = '0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_allow_in = 1'b1;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rs1_en = 1'b0; in_rs2_en = 1'b0;
    in_rd_en = 1'b0; in_payload = '0;
    clr_byp();
    fork monitor(); join_none

    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_allow_in", 128'(in_allow_in), 128'd1);
    chk("rst_stall_cnt", 128'(stall_cnt), 128'd0);
    chk("rst_out_src1", 128'(out_src1), 128'd0);
    chk("rst_out_payload", 128'(out_payload), 128'd0);
    step();
    reset = 1'b0;

    // Back-to-back RF issue, then x0 / disabled operands read as zero
    offer(5'd3, 1, 5'd4, 1, 5'd7, 1, 96'h1, 32'h1003, 32'h1004, 1);
    offer(5'd0, 1, 5'd9, 0, 5'd2, 0, 96'h2, 32'h0, 32'h0, 1);

    // x0 never matches a bypass
    byp_addr[0] = 5'd0; byp_data[0] = 32'hDEAD; byp_wen[0] = 1; byp_dvalid[0] = 1;
    offer(5'd2, 1, 5'd0, 1, 5'd3, 1, 96'h3, 32'h1002, 32'h0, 1);
    @(negedge clk);
    chk("x0_issue_next_cycle", 128'(out_valid), 128'd1);

    // Youngest bypass wins even when not yet final
    byp_addr[0] = 5'd5; byp_wen[0] = 1; byp_dvalid[0] = 0; byp_data[0] = 32'hBEEF;
    byp_addr[1] = 5'd5; byp_wen[1] = 1; byp_dvalid[1] = 1; byp_data[1] = 32'h11;
    offer(5'd5, 1, 5'd0, 0, 5'd4, 1, 96'h4, 32'h22, 32'h0, 1);
    @(negedge clk);
    chk("young_stalled", 128'(out_valid), 128'd0);
    step();
    byp_dvalid[0] = 1; byp_data[0] = 32'h22;
    @(negedge clk);
    chk("young_stall_cnt", 128'(stall_cnt), 128'd1);
    step();
    clr_byp();

    // Capture under back-pressure
    out_allow_in = 1'b0;
    byp_addr[2] = 5'd6; byp_wen[2] = 1; byp_dvalid[2] = 1; byp_data[2] = 32'h33;
    offer(5'd6, 1, 5'd8, 1, 5'd5, 1, 96'h5, 32'h33, 32'h1008, 1);
    @(negedge clk);
    chk("cap_out_valid", 128'(out_valid), 128'd1);
    step();
    byp_data[2] = 32'h44;
    step();
    out_allow_in = 1'b1;
    @(negedge clk);
    chk("backpressure_not_stall", 128'(stall_cnt), 128'd1);
    step();
    clr_byp();

    // Flush while stalled, with a simultaneous offer
    byp_addr[0] = 5'd7; byp_wen[0] = 1; byp_dvalid[0] = 0;
    offer(5'd7, 1, 5'd0, 0, 5'd6, 1, 96'h7, 32'h0, 32'h0, 0);
    flush = 1'b1; in_valid = 1'b1; in_rs1 = 5'd1; in_rs1_en = 1'b0;
    in_rs2_en = 1'b0; in_payload = 96'hBAD;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 128'(out_valid), 128'd0);
    chk("flush_in_allow_in", 128'(in_allow_in), 128'd1);
    chk("flush_stall_cnt", 128'(stall_cnt), 128'd1);
    chk("flush_offer_dropped", 128'(out_payload), 128'h7);
    step();
    clr_byp();

    // Stall counter saturation
    byp_addr[0] = 5'd9; byp_wen[0] = 1; byp_dvalid[0] = 0;
    offer(5'd9, 1, 5'd0, 0, 5'd9, 1, 96'h9, 32'h55, 32'h0, 1);
    @(negedge clk);
    force dut.stall_q = 32'hFFFF_FFFE;
    #1 release dut.stall_q;
    step(); step(); step();
    @(negedge clk);
    chk("stall_saturate", 128'(stall_cnt), 128'hFFFF_FFFF);
    step();
    byp_dvalid[0] = 1; byp_data[0] = 32'h55;
    step();
    clr_byp();
    step(); step();

    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
